// File: rtl/smpl_cnt_tracker.sv
// Per-triangle fragment-count checker: sums lane hits per triangle tag, closes on tag change
// or flush, and compares each closed count against an expected-count FIFO.
module smpl_cnt_tracker #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TAG_W     = 16,
    parameter int unsigned EXP_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tri_valid_R18H,
    input  logic [TAG_W-1:0] tri_tag_R18U,
    input  logic [LANES-1:0] hit_valid_R18H,
    input  logic             flush_R18H,
    input  logic             exp_push,
    input  logic [TAG_W-1:0] exp_tag,
    input  logic [CNT_W-1:0] exp_count,
    output logic             exp_full,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic [CNT_W-1:0] done_count,
    output logic             cnt_mismatch,
    output logic             tag_mismatch,
    output logic             exp_underflow,
    output logic             err_sticky,
    output logic [15:0]      err_count
);

    localparam int unsigned POP_W = $clog2(LANES + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam int unsigned PTR_W = $clog2(EXP_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    // Returns {saturated, value}.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [POP_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > CNT_MAX) return {1'b1, {CNT_W{1'b1}}};
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    state_e           r_state, w_state_d;
    logic [TAG_W-1:0] r_cur_tag, w_tag_d;
    logic [CNT_W-1:0] r_acc, w_acc_d;
    logic             r_sat, w_sat_d;

    logic             r_pend;
    logic [TAG_W-1:0] r_pend_tag;
    logic [CNT_W-1:0] r_pend_cnt;
    logic             r_pend_sat;

    logic [TAG_W-1:0] r_fifo_tag [EXP_DEPTH];
    logic [CNT_W-1:0] r_fifo_cnt [EXP_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [OCC_W-1:0] r_occ, w_occ_d;
    logic             r_exp_full;

    logic             r_done_valid, r_cnt_mm, r_tag_mm, r_underflow, r_sticky;
    logic [TAG_W-1:0] r_done_tag;
    logic [CNT_W-1:0] r_done_count;
    logic [15:0]      r_err_count;

    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_inc_same, w_inc_new;
    logic             w_sat_evt;
    logic             w_a_vld, w_a_sat, w_b_vld, w_b_sat;
    logic [TAG_W-1:0] w_a_tag, w_b_tag;
    logic [CNT_W-1:0] w_a_cnt, w_b_cnt;
    logic             w_close_vld, w_close_sat, w_pend_d;
    logic [TAG_W-1:0] w_close_tag;
    logic [CNT_W-1:0] w_close_cnt;
    logic             w_empty, w_fifo_pop, w_push_ok, w_push_drop;
    logic             w_underflow, w_tag_mm, w_cnt_mm, w_err_close;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_pop = w_pop + POP_W'(hit_valid_R18H[i] & tri_valid_R18H);
        end
    end

    assign w_inc_same = sat_add(r_acc, w_pop);
    assign w_inc_new  = sat_add('0, w_pop);

    // Close A retires the currently open triangle; close B retires a triangle opened and
    // flushed in the same cycle.
    always_comb begin
        w_state_d = r_state;
        w_tag_d   = r_cur_tag;
        w_acc_d   = r_acc;
        w_sat_d   = r_sat;
        w_sat_evt = 1'b0;
        w_a_vld   = 1'b0;
        w_a_tag   = r_cur_tag;
        w_a_cnt   = r_acc;
        w_a_sat   = r_sat;
        w_b_vld   = 1'b0;
        w_b_tag   = tri_tag_R18U;
        w_b_cnt   = w_inc_new[CNT_W-1:0];
        w_b_sat   = w_inc_new[CNT_W];
        unique case (r_state)
            StIdle: begin
                if (tri_valid_R18H) begin
                    w_sat_evt = w_inc_new[CNT_W];
                    if (flush_R18H) begin
                        w_b_vld = 1'b1;
                    end else begin
                        w_state_d = StAccum;
                        w_tag_d   = tri_tag_R18U;
                        w_acc_d   = w_inc_new[CNT_W-1:0];
                        w_sat_d   = w_inc_new[CNT_W];
                    end
                end
            end
            StAccum: begin
                if (tri_valid_R18H && (tri_tag_R18U == r_cur_tag)) begin
                    w_sat_evt = w_inc_same[CNT_W];
                    w_acc_d   = w_inc_same[CNT_W-1:0];
                    w_sat_d   = r_sat | w_inc_same[CNT_W];
                    if (flush_R18H) begin
                        w_a_vld   = 1'b1;
                        w_a_cnt   = w_inc_same[CNT_W-1:0];
                        w_a_sat   = r_sat | w_inc_same[CNT_W];
                        w_state_d = StIdle;
                    end
                end else if (tri_valid_R18H) begin
                    w_a_vld   = 1'b1;
                    w_sat_evt = w_inc_new[CNT_W];
                    w_tag_d   = tri_tag_R18U;
                    w_acc_d   = w_inc_new[CNT_W-1:0];
                    w_sat_d   = w_inc_new[CNT_W];
                    if (flush_R18H) begin
                        w_b_vld   = 1'b1;
                        w_state_d = StIdle;
                    end
                end else if (flush_R18H) begin
                    w_a_vld   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_state_d == StIdle) begin
            w_acc_d = '0;
            w_sat_d = 1'b0;
        end
    end

    // Pending is only set on the way to idle, so it never coincides with close A; the
    // leftover close is therefore always B.
    always_comb begin
        w_close_vld = r_pend | w_a_vld | w_b_vld;
        w_close_tag = w_b_tag;
        w_close_cnt = w_b_cnt;
        w_close_sat = w_b_sat;
        if (r_pend) begin
            w_close_tag = r_pend_tag;
            w_close_cnt = r_pend_cnt;
            w_close_sat = r_pend_sat;
        end else if (w_a_vld) begin
            w_close_tag = w_a_tag;
            w_close_cnt = w_a_cnt;
            w_close_sat = w_a_sat;
        end
        w_pend_d = r_pend ? w_b_vld : (w_a_vld & w_b_vld);
    end

    assign w_empty     = (r_occ == '0);
    assign w_fifo_pop  = w_close_vld & ~w_empty;
    assign w_push_ok   = exp_push & ((r_occ != OCC_W'(EXP_DEPTH)) | w_fifo_pop);
    assign w_push_drop = exp_push & ~w_push_ok;
    assign w_occ_d     = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_fifo_pop);

    assign w_underflow = w_close_vld & w_empty;
    assign w_tag_mm    = w_fifo_pop & (r_fifo_tag[r_rd_ptr] != w_close_tag);
    assign w_cnt_mm    = w_fifo_pop & ((r_fifo_cnt[r_rd_ptr] != w_close_cnt) | w_close_sat);
    assign w_err_close = w_underflow | w_tag_mm | w_cnt_mm;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_tag[r_wr_ptr] <= exp_tag;
            r_fifo_cnt[r_wr_ptr] <= exp_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cur_tag    <= '0;
            r_acc        <= '0;
            r_sat        <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_tag   <= '0;
            r_pend_cnt   <= '0;
            r_pend_sat   <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_occ        <= '0;
            r_exp_full   <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_tag   <= '0;
            r_done_count <= '0;
            r_cnt_mm     <= 1'b0;
            r_tag_mm     <= 1'b0;
            r_underflow  <= 1'b0;
            r_sticky     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cur_tag  <= w_tag_d;
            r_acc      <= w_acc_d;
            r_sat      <= w_sat_d;
            r_pend     <= w_pend_d;
            if (w_pend_d) begin
                r_pend_tag <= w_b_tag;
                r_pend_cnt <= w_b_cnt;
                r_pend_sat <= w_b_sat;
            end
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ        <= w_occ_d;
            r_exp_full   <= (w_occ_d == OCC_W'(EXP_DEPTH));
            r_done_valid <= w_close_vld;
            if (w_close_vld) begin
                r_done_tag   <= w_close_tag;
                r_done_count <= w_close_cnt;
            end
            r_cnt_mm    <= w_cnt_mm;
            r_tag_mm    <= w_tag_mm;
            r_underflow <= w_underflow;
            r_sticky    <= r_sticky | w_err_close | w_push_drop | w_sat_evt;
            if (w_err_close && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign exp_full      = r_exp_full;
    assign done_valid    = r_done_valid;
    assign done_tag      = r_done_tag;
    assign done_count    = r_done_count;
    assign cnt_mismatch  = r_cnt_mm;
    assign tag_mismatch  = r_tag_mm;
    assign exp_underflow = r_underflow;
    assign err_sticky    = r_sticky;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_smpl_cnt_tracker.sv
// Bench for smpl_cnt_tracker: directed vector table, FIFO/saturation/reset sequences, and
// randomized traffic checked against a queue-based triangle model.
module tb_smpl_cnt_tracker;

    typedef struct packed {
        bit          tv;
        logic [15:0] tag;
        logic [3:0]  hits;
        bit          flush;
        bit          push;
        logic [15:0] etag;
        logic [31:0] ecnt;
    } in_t;

    typedef struct packed {
        bit          dv;
        logic [15:0] dtag;
        logic [31:0] dcnt;
        bit          cmm;
        bit          tmm;
        bit          und;
        bit          stk;
        logic [15:0] ecn;
        bit          full;
    } ex_t;

    typedef struct {
        in_t i;
        ex_t e;
    } vec_t;

    typedef struct {
        int     tag;
        longint cnt;
    } tc_t;

    logic        clk;
    logic        rst;
    logic        tv;
    logic [15:0] tag;
    logic [3:0]  hits;
    logic        flush;
    logic        exp_push;
    logic [15:0] exp_tag;
    logic [31:0] exp_count;
    logic [2:0]  exp_count_s;

    logic        m_full, m_dv, m_cmm, m_tmm, m_und, m_stk;
    logic [15:0] m_dtag, m_ecn;
    logic [31:0] m_dcnt;
    logic        s_full, s_dv, s_cmm, s_tmm, s_und, s_stk;
    logic [15:0] s_dtag, s_ecn;
    logic [2:0]  s_dcnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit     md_open;
    int     md_tag;
    longint md_cnt;
    tc_t    md_closeq[$];
    tc_t    md_fifo[$];
    bit     md_stk;
    int     md_errc;

    smpl_cnt_tracker u_dut (
        .clk            (clk),
        .rst            (rst),
        .tri_valid_R18H (tv),
        .tri_tag_R18U   (tag),
        .hit_valid_R18H (hits),
        .flush_R18H     (flush),
        .exp_push       (exp_push),
        .exp_tag        (exp_tag),
        .exp_count      (exp_count),
        .exp_full       (m_full),
        .done_valid     (m_dv),
        .done_tag       (m_dtag),
        .done_count     (m_dcnt),
        .cnt_mismatch   (m_cmm),
        .tag_mismatch   (m_tmm),
        .exp_underflow  (m_und),
        .err_sticky     (m_stk),
        .err_count      (m_ecn)
    );

    smpl_cnt_tracker #(
        .LANES     (4),
        .CNT_W     (3),
        .TAG_W     (16),
        .EXP_DEPTH (8)
    ) u_sat (
        .clk            (clk),
        .rst            (rst),
        .tri_valid_R18H (tv),
        .tri_tag_R18U   (tag),
        .hit_valid_R18H (hits),
        .flush_R18H     (flush),
        .exp_push       (exp_push),
        .exp_tag        (exp_tag),
        .exp_count      (exp_count_s),
        .exp_full       (s_full),
        .done_valid     (s_dv),
        .done_tag       (s_dtag),
        .done_count     (s_dcnt),
        .cnt_mismatch   (s_cmm),
        .tag_mismatch   (s_tmm),
        .exp_underflow  (s_und),
        .err_sticky     (s_stk),
        .err_count      (s_ecn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t vin(input bit v, input int tg, input bit [3:0] h, input bit fl,
                                input bit pu, input int et, input int ec);
        in_t r;
        r.tv = v; r.tag = 16'(tg); r.hits = h; r.flush = fl;
        r.push = pu; r.etag = 16'(et); r.ecnt = 32'(ec);
        return r;
    endfunction

    function automatic ex_t vex(input bit v, input int dt, input int dc, input bit cm,
                                input bit tm, input bit uf, input bit st, input int ec,
                                input bit fu);
        ex_t r;
        r.dv = v; r.dtag = 16'(dt); r.dcnt = 32'(dc); r.cmm = cm; r.tmm = tm;
        r.und = uf; r.stk = st; r.ecn = 16'(ec); r.full = fu;
        return r;
    endfunction

    task automatic drive(input in_t i);
        tv = i.tv; tag = i.tag; hits = i.hits; flush = i.flush;
        exp_push = i.push; exp_tag = i.etag; exp_count = i.ecnt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input ex_t e, input bit dv, input logic [15:0] dt,
                         input logic [31:0] dc, input bit cm, input bit tm, input bit uf,
                         input bit st, input logic [15:0] ec, input bit fu);
        bit ok;
        n_checks++;
        ok = (dv == e.dv) && (cm == e.cmm) && (tm == e.tmm) && (uf == e.und) &&
             (st == e.stk) && (ec == e.ecn) && (fu == e.full);
        if (e.dv) ok = ok && (dt == e.dtag) && (dc == e.dcnt);
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got v=%0b tag=%0d cnt=%0d cm=%0b tm=%0b uf=%0b stk=%0b ec=%0d full=%0b; want v=%0b tag=%0d cnt=%0d cm=%0b tm=%0b uf=%0b stk=%0b ec=%0d full=%0b",
                     nm, dv, dt, dc, cm, tm, uf, st, ec, fu,
                     e.dv, e.dtag, e.dcnt, e.cmm, e.tmm, e.und, e.stk, e.ecn, e.full);
        end
    endtask

    task automatic chk_main(input string nm, input ex_t e);
        check(nm, e, m_dv, m_dtag, m_dcnt, m_cmm, m_tmm, m_und, m_stk, m_ecn, m_full);
    endtask

    task automatic chk_sat(input string nm, input ex_t e);
        check(nm, e, s_dv, s_dtag, 32'(s_dcnt), s_cmm, s_tmm, s_und, s_stk, s_ecn, s_full);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(vin(0, 0, 4'b0000, 0, 0, 0, 0));
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Triangle-level model: closes are queued in order, one reported per cycle.
    task automatic model_step(input in_t i, output ex_t e);
        longint p;
        tc_t    c;
        tc_t    h;
        p = i.tv ? longint'($countones(i.hits)) : 0;
        if (md_open) begin
            if (i.tv && int'(i.tag) == md_tag) begin
                md_cnt += p;
                if (i.flush) begin md_closeq.push_back('{md_tag, md_cnt}); md_open = 0; end
            end else if (i.tv) begin
                md_closeq.push_back('{md_tag, md_cnt});
                md_tag = int'(i.tag);
                md_cnt = p;
                if (i.flush) begin md_closeq.push_back('{md_tag, md_cnt}); md_open = 0; end
            end else if (i.flush) begin
                md_closeq.push_back('{md_tag, md_cnt});
                md_open = 0;
            end
        end else if (i.tv) begin
            md_tag  = int'(i.tag);
            md_cnt  = p;
            md_open = 1;
            if (i.flush) begin md_closeq.push_back('{md_tag, md_cnt}); md_open = 0; end
        end
        e = vex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (md_closeq.size() > 0) begin
            c      = md_closeq.pop_front();
            e.dv   = 1;
            e.dtag = 16'(c.tag);
            e.dcnt = 32'(c.cnt);
            if (md_fifo.size() == 0) begin
                e.und = 1;
            end else begin
                h     = md_fifo.pop_front();
                e.tmm = (h.tag != c.tag);
                e.cmm = (h.cnt != c.cnt);
            end
            if (e.und || e.tmm || e.cmm) begin
                md_stk = 1;
                if (md_errc < 65535) md_errc++;
            end
        end
        if (i.push) begin
            if (md_fifo.size() < 8) md_fifo.push_back('{int'(i.etag), longint'(i.ecnt)});
            else md_stk = 1;
        end
        e.full = (md_fifo.size() == 8);
        e.stk  = md_stk;
        e.ecn  = 16'(md_errc);
    endtask

    initial begin
        vec_t vq[$];
        ex_t  e;
        in_t  ri;
        ex_t  zero;
        zero = vex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_count_s = 3'd0;

        do_reset();
        chk_main("reset_main", zero);
        chk_sat("reset_sat", zero);

        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 5, 6), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(1, 5, 4'b1111, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(1, 5, 4'b0011, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 1, 0, 0, 0), vex(1, 5, 6, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 7, 3), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 8, 2), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(1, 7, 4'b0111, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(1, 8, 4'b1001, 0, 0, 0, 0), vex(1, 7, 3, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 1, 0, 0, 0), vex(1, 8, 2, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 9, 4), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(1, 9, 4'b0001, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 1, 0, 0, 0), vex(1, 9, 1, 1, 0, 0, 1, 1, 0)});
        vq.push_back('{vin(1, 3, 4'b1111, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 1, 1, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 1, 0, 0, 0), vex(1, 3, 4, 0, 0, 1, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 10, 2), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 11, 1), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(1, 10, 4'b0011, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(1, 11, 4'b0100, 1, 0, 0, 0), vex(1, 10, 2, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 0, 0, 0), vex(1, 11, 1, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 0, 1, 12, 1), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(1, 13, 4'b0001, 0, 0, 0, 0), vex(0, 0, 0, 0, 0, 0, 1, 2, 0)});
        vq.push_back('{vin(0, 0, 4'b0000, 1, 0, 0, 0), vex(1, 13, 1, 0, 1, 0, 1, 3, 0)});

        foreach (vq[k]) begin
            drive(vq[k].i);
            tick();
            chk_main($sformatf("vec%0d", k), vq[k].e);
        end

        // FIFO full / overflow / push-during-close
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(vin(0, 0, 4'b0000, 0, 1, 20 + k, 1));
            tick();
        end
        chk_main("fill8", vex(0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(vin(0, 0, 4'b0000, 0, 1, 50, 1));
        tick();
        chk_main("push_full_drop", vex(0, 0, 0, 0, 0, 0, 1, 0, 1));
        drive(vin(1, 20, 4'b0001, 0, 0, 0, 0));
        tick();
        chk_main("open20", vex(0, 0, 0, 0, 0, 0, 1, 0, 1));
        drive(vin(0, 0, 4'b0000, 1, 1, 99, 2));
        tick();
        chk_main("close_push_full", vex(1, 20, 1, 0, 0, 0, 1, 0, 1));
        for (int k = 21; k < 28; k++) begin
            drive(vin(1, k, 4'b0001, 0, 0, 0, 0));
            tick();
            drive(vin(0, 0, 4'b0000, 1, 0, 0, 0));
            tick();
            chk_main($sformatf("drain%0d", k), vex(1, k, 1, 0, 0, 0, 1, 0, 0));
        end
        drive(vin(1, 99, 4'b0011, 0, 0, 0, 0));
        tick();
        drive(vin(0, 0, 4'b0000, 1, 0, 0, 0));
        tick();
        chk_main("drain99", vex(1, 99, 2, 0, 0, 0, 1, 0, 0));

        // Saturation on the narrow instance, then reset mid-triangle
        do_reset();
        exp_count_s = 3'd7;
        drive(vin(0, 0, 4'b0000, 0, 1, 1, 7));
        tick();
        exp_count_s = 3'd0;
        drive(vin(1, 1, 4'b1111, 0, 0, 0, 0));
        tick();
        tick();
        chk_sat("sat_accum", vex(0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(vin(0, 0, 4'b0000, 1, 0, 0, 0));
        tick();
        chk_sat("sat_close", vex(1, 1, 7, 1, 0, 0, 1, 1, 0));
        chk_main("wide_close", vex(1, 1, 8, 1, 0, 0, 1, 1, 0));
        drive(vin(1, 2, 4'b1111, 0, 1, 2, 4));
        tick();
        rst = 1'b1;
        drive(vin(0, 0, 4'b0000, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        chk_main("rst_mid_main", zero);
        chk_sat("rst_mid_sat", zero);
        drive(vin(0, 0, 4'b0000, 1, 0, 0, 0));
        tick();
        chk_main("post_rst_flush_main", zero);
        chk_sat("post_rst_flush_sat", zero);

        // Randomized traffic against the model
        do_reset();
        md_open = 0;
        md_closeq.delete();
        md_fifo.delete();
        md_stk  = 0;
        md_errc = 0;
        for (int c = 0; c < 3000; c++) begin
            ri = vin($urandom_range(0, 9) < 7, $urandom_range(0, 3), 4'($urandom),
                     $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 3), $urandom_range(0, 6));
            model_step(ri, e);
            drive(ri);
            tick();
            chk_main($sformatf("rand%0d", c), e);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
